// File: rtl/button_event_queue_pkg.sv
// Shared constants for the button event queue: button indices, event codes
// and the default auto-repeat mask.
package button_event_queue_pkg;

  typedef enum logic [2:0] {
    EV_NONE        = 3'd0,
    EV_RIGHT       = 3'd1,
    EV_LEFT        = 3'd2,
    EV_DOWN        = 3'd3,
    EV_UP          = 3'd4,
    EV_DECISION    = 3'd5,
    EV_RED_RESET   = 3'd6,
    EV_BLUE_RESET  = 3'd7
  } event_code_t;

  localparam int unsigned BTN_RIGHT      = 0;
  localparam int unsigned BTN_LEFT       = 1;
  localparam int unsigned BTN_DOWN       = 2;
  localparam int unsigned BTN_UP         = 3;
  localparam int unsigned BTN_DECISION   = 4;
  localparam int unsigned BTN_RED_RESET  = 5;
  localparam int unsigned BTN_BLUE_RESET = 6;

  localparam logic [6:0] REPEAT_MASK_DEF = 7'b0001111;

  function automatic event_code_t code_of(input logic [2:0] idx);
    return event_code_t'(3'(idx + 3'd1));
  endfunction

endpackage

// File: rtl/button_debounce_repeat.sv
// One button: 2-FF synchroniser, debounce to a clean level, and a one-cycle
// request pulse on press and (when enabled) on each auto-repeat slot.
module button_debounce_repeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic req
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic            s1, s2;
  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rp_cnt;
  logic            rp_first;
  logic            flip, press, fall, repeat_hit;

  assign flip  = (s2 != level) && (db_cnt == DB_LAST);
  assign press = flip && s2;
  assign fall  = flip && !s2;
  // The release edge itself never issues a repeat, even if the slot lands on it.
  assign repeat_hit = repeat_en && level && !fall &&
                      (rp_cnt == (rp_first ? DELAY_LAST : PERIOD_LAST));
  assign req = press || repeat_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      level    <= 1'b0;
      db_cnt   <= '0;
      rp_cnt   <= '0;
      rp_first <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;

      if (s2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (press) begin
        rp_cnt   <= '0;
        rp_first <= 1'b1;
      end else if (!level || fall || !repeat_en) begin
        rp_cnt <= '0;
      end else if (repeat_hit) begin
        rp_cnt   <= '0;
        rp_first <= 1'b0;
      end else begin
        rp_cnt <= rp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Conditions the raw push-buttons into single move events held in a one-deep
// event register with a valid/ack handshake; debounced levels are exported.
module button_event_queue
  import button_event_queue_pkg::*;
#(
  parameter int unsigned      N_BTN           = 7,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned      REPEAT_DELAY    = 50000000,
  parameter int unsigned      REPEAT_PERIOD   = 12500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             event_valid,
  output logic [2:0]       event_code,
  input  logic             event_ack,
  output logic             event_dropped
);

  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant_oh;
  logic [2:0]       grant_idx;
  logic             grant_any;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn (
      .clk       (clk),
      .reset     (reset),
      .raw       (btn_raw[i]),
      .repeat_en (REPEAT_MASK[i]),
      .level     (btn_level[i]),
      .req       (req[i])
    );
  end

  // Ascending scan so the highest pending index is the one left in grant_idx.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (pending[i]) grant_idx = 3'(i);
    end
    grant_any = (!event_valid || event_ack) && (|pending);
    grant_oh  = grant_any ? (N_BTN'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      event_valid   <= 1'b0;
      event_code    <= EV_NONE;
      event_dropped <= 1'b0;
    end else begin
      // A request landing on the bit being granted re-arms it rather than merging.
      pending <= (pending & ~grant_oh) | req;
      if (|(req & pending & ~grant_oh)) event_dropped <= 1'b1;

      if (grant_any) begin
        event_valid <= 1'b1;
        event_code  <= code_of(grant_idx);
      end else if (event_valid && event_ack) begin
        event_valid <= 1'b0;
        event_code  <= EV_NONE;
      end
    end
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with a cycle-level behavioural model
// and literal checkpoints for the six scenarios.
module tb_button_event_queue;
  import button_event_queue_pkg::*;

  localparam int unsigned N  = 7;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
  localparam logic [6:0] MASK = 7'b0001111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       event_ack = 1'b0;
  logic [6:0] btn_raw = '0;
  logic [6:0] btn_level;
  logic       event_valid;
  logic [2:0] event_code;
  logic       event_dropped;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  button_event_queue #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .event_ack     (event_ack),
    .event_dropped (event_dropped)
  );

  // Behavioural model: level follows s2 once it has been stable for D samples;
  // events come from a press and from scheduled repeat times since the press.
  bit [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_rq;
  bit [D-1:0] m_hist [N];
  int         m_press [N];
  int         cyc, m_g, m_d, m_code;
  bit         m_valid, m_drop;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
    for (int i = 0; i < N; i++) begin m_hist[i] = '0; m_press[i] = 0; end
    cyc = 0; m_valid = 0; m_code = 0; m_drop = 0;
  endtask

  task automatic model_step();
    cyc++;
    m_rq = '0;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = {m_hist[i][D-2:0], m_s2[i]};
      if (!m_lvl[i] && m_hist[i] == '1) begin
        m_lvl[i] = 1'b1; m_press[i] = cyc; m_rq[i] = 1'b1;
      end else if (m_lvl[i] && m_hist[i] == '0) begin
        m_lvl[i] = 1'b0;
      end else if (m_lvl[i] && MASK[i]) begin
        m_d = cyc - m_press[i];
        if (m_d == RD || (m_d > RD && (m_d - RD) % RP == 0)) m_rq[i] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;

    m_g = -1;
    if (!m_valid || event_ack)
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_g < 0) m_g = i;
    for (int i = 0; i < N; i++)
      if (m_rq[i] && m_pend[i] && i != m_g) m_drop = 1'b1;
    if (m_g >= 0) begin
      m_valid = 1'b1; m_code = m_g + 1; m_pend[m_g] = 1'b0;
    end else if (m_valid && event_ack) begin
      m_valid = 1'b0; m_code = 0;
    end
    m_pend = m_pend | m_rq;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_btn_level", 32'(btn_level), 32'(m_lvl));
    check("model_event_valid", 32'(event_valid), 32'(m_valid));
    check("model_event_code", 32'(event_code), 32'(m_code));
    check("model_event_dropped", 32'(event_dropped), 32'(m_drop));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    btn_raw = '0;
    event_ack = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  int n_ev;

  initial begin
    // 1: clean press of right, held 10 cycles, no ack
    do_reset();
    btn_raw[BTN_RIGHT] = 1'b1;
    tick(5);
    check("t1_level_before", 32'(btn_level[0]), 0);
    tick(1);
    check("t1_level_edge5", 32'(btn_level[0]), 1);
    check("t1_valid_edge5", 32'(event_valid), 0);
    tick(1);
    check("t1_valid_edge6", 32'(event_valid), 1);
    check("t1_code_edge6", 32'(event_code), 32'(EV_RIGHT));
    tick(3);
    btn_raw[BTN_RIGHT] = 1'b0;
    tick(10);
    check("t1_hold_valid", 32'(event_valid), 1);
    check("t1_hold_code", 32'(event_code), 32'(EV_RIGHT));
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    check("t1_ack_valid", 32'(event_valid), 0);
    check("t1_ack_code", 32'(event_code), 0);
    tick(5);
    check("t1_no_second", 32'(event_valid), 0);

    // 2: bouncing up button, then a clean hold
    do_reset();
    for (int k = 0; k < 4; k++) begin
      btn_raw[BTN_UP] = (k % 2 == 0);
      tick(2);
      check("t2_bounce_valid", 32'(event_valid), 0);
    end
    btn_raw[BTN_UP] = 1'b1;
    tick(6);
    check("t2_valid_edge5", 32'(event_valid), 0);
    tick(1);
    check("t2_valid_edge6", 32'(event_valid), 1);
    check("t2_code_edge6", 32'(event_code), 32'(EV_UP));
    btn_raw[BTN_UP] = 1'b0;
    event_ack = 1'b1;
    tick(12);
    check("t2_single_event", 32'(event_valid), 0);
    event_ack = 1'b0;

    // 3: left held 60 cycles with ack always high -> press plus five repeats
    do_reset();
    event_ack = 1'b1;
    btn_raw[BTN_LEFT] = 1'b1;
    n_ev = 0;
    for (int k = 0; k < 90; k++) begin
      if (k == 60) btn_raw[BTN_LEFT] = 1'b0;
      tick(1);
      if (event_valid && event_code == 3'(EV_LEFT)) n_ev++;
    end
    check("t3_event_count", 32'(n_ev), 6);
    event_ack = 1'b0;

    // 4: blue_reset and decision together -> 7 then 5 back to back
    do_reset();
    btn_raw[BTN_BLUE_RESET] = 1'b1;
    btn_raw[BTN_DECISION] = 1'b1;
    tick(7);
    check("t4_first_valid", 32'(event_valid), 1);
    check("t4_first_code", 32'(event_code), 32'(EV_BLUE_RESET));
    event_ack = 1'b1;
    tick(1);
    check("t4_second_valid", 32'(event_valid), 1);
    check("t4_second_code", 32'(event_code), 32'(EV_DECISION));
    tick(1);
    check("t4_empty_valid", 32'(event_valid), 0);
    check("t4_empty_code", 32'(event_code), 0);
    event_ack = 1'b0;
    btn_raw = '0;
    tick(8);

    // 5: down held, never acked -> first repeat merges, second is dropped
    do_reset();
    btn_raw[BTN_DOWN] = 1'b1;
    tick(7);
    check("t5_first_code", 32'(event_code), 32'(EV_DOWN));
    tick(20);
    check("t5_drop_after_rep1", 32'(event_dropped), 0);
    tick(8);
    check("t5_drop_after_rep2", 32'(event_dropped), 1);
    check("t5_still_valid", 32'(event_valid), 1);
    check("t5_still_code", 32'(event_code), 32'(EV_DOWN));
    btn_raw = '0;
    event_ack = 1'b1;
    tick(10);
    check("t5_drop_sticky", 32'(event_dropped), 1);
    event_ack = 1'b0;

    // 6: reset mid-hold with an event valid, button still held afterwards
    do_reset();
    btn_raw[BTN_RIGHT] = 1'b1;
    tick(7);
    check("t6_valid_before", 32'(event_valid), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_level", 32'(btn_level), 0);
    check("t6_rst_valid", 32'(event_valid), 0);
    check("t6_rst_code", 32'(event_code), 0);
    check("t6_rst_dropped", 32'(event_dropped), 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("t6_valid_edge5", 32'(event_valid), 0);
    check("t6_level_edge5", 32'(btn_level[0]), 1);
    tick(1);
    check("t6_valid_edge6", 32'(event_valid), 1);
    check("t6_code_edge6", 32'(event_code), 32'(EV_RIGHT));
    btn_raw = '0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Upstream stage for the game top level: conditions the seven raw push-buttons into single, clean move events.
- Button order: blue_reset, red_reset, decision, up, down, left, right.
- Per button: 2-FF synchronise, debounce, detect press; direction buttons also auto-repeat while held.
- A one-deep event register with valid/ack handshake replaces raw button levels at the direction encoder / state-transition input. Debounced levels are also exported for the score-reset logic.

Parameters:
- N_BTN, 7: number of buttons; bit 6 = blue_reset … bit 0 = right.
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles of a stable new level before the debounced level changes (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles from debounced press to the first repeat event.
- REPEAT_PERIOD, 12500000: cycles between subsequent repeat events.
- REPEAT_MASK, 7'b0001111: buttons allowed to auto-repeat (directions only).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- btn_raw, input, N_BTN: raw button levels, asynchronous, 1 = pressed.
- btn_level, output, N_BTN: debounced levels.
- event_valid, output, 1: an event is held in event_code.
- event_code, output, 3: 0 none; 1 right, 2 left, 3 down, 4 up, 5 decision, 6 red_reset, 7 blue_reset (bit index + 1).
- event_ack, input, 1: consumer takes the event; meaningful only while event_valid = 1.
- event_dropped, output, 1: sticky flag; an event merged into an already-pending request.

Behaviour:
- Reset (async, immediate) clears: sync FFs, btn_level, debounce counters, repeat counters, pending bits, event_valid, event_code, event_dropped.
- Synchroniser: s1 <= btn_raw; s2 <= s1.
- Debounce, per bit:
  - If s2 == btn_level, counter <= 0.
  - Otherwise counter increments; when counter == DEBOUNCE_CYCLES-1, btn_level <= s2 and counter <= 0.
  - Any bounce back to btn_level restarts the count.
- Press: a 0->1 flip of btn_level[i] sets pending[i] on the same edge.
  - A 1->0 flip produces no event.
- Auto-repeat, per bit with REPEAT_MASK[i] = 1:
  - Repeat counter is zeroed on the press flip.
  - First repeat sets pending[i] REPEAT_DELAY cycles after the flip, then every REPEAT_PERIOD cycles, while btn_level[i] stays 1.
  - Release zeroes the counter immediately; no repeat is issued on the release cycle.
- Merge: a press or repeat of bit i while pending[i] = 1 is dropped and sets event_dropped (cleared only by reset).
- Grant: when event_valid = 0, or event_valid = 1 and event_ack = 1, and any pending bit is set:
  - The highest-index pending bit wins.
  - event_code <= index + 1, event_valid <= 1, and that pending bit is cleared, all on the same edge.
  - This gives back-to-back events with no bubble.
- Ack with nothing pending: event_valid <= 0, event_code <= 0.
- Stability: event_code is stable while event_valid = 1 and event_ack = 0. event_ack while event_valid = 0 is ignored.
- Same-cycle collision: if a new press of bit i arrives on the same edge its pending bit is granted, the set wins and pending[i] stays 1 (one extra event, not dropped).
- Latency: raw held high from before edge 0, clean, with nothing else pending:
  - btn_level rises after edge DEBOUNCE_CYCLES+1.
  - event_valid rises after edge DEBOUNCE_CYCLES+2.
- Reset released while a button is held: btn_level starts at 0, so a normal press event follows after the latency above.
- Counter widths: $clog2 of the respective parameter; no wrap is reachable because counters reload before overflow.

Decomposition:
- Shared package holds:
  - event code constants EV_NONE, EV_RIGHT … EV_BLUE_RESET;
  - button index constants BTN_RIGHT … BTN_BLUE_RESET;
  - default REPEAT_MASK.
- One sub-module, button_debounce_repeat: one bit of sync + debounce + repeat, emitting level and a one-cycle request pulse.
- It is instantiated N_BTN times via generate, with its repeat enable tied to REPEAT_MASK[i].
- The top holds the pending vector, priority grant and event register.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Clean press of btn_raw[0] at edge 0, held 10 cycles, no ack -> btn_level[0]=1 after edge 5; event_valid=1, event_code=1 after edge 6; holds until ack; no second event.
2. btn_raw[3] toggled 1,0,1,0 every 2 cycles, then held high -> no event during the bounce; exactly one event code 4, 6 cycles after the final rising edge.
3. btn_raw[1] held 60 cycles with ack the cycle after each valid -> event code 2 at press, then repeats at flip+20, +28, +36, +44, +52; none after release.
4. btn_raw[6] and btn_raw[4] pressed on the same cycle -> code 7 first; ack -> code 5 on the next cycle (back-to-back, valid stays high); second ack -> event_valid=0, event_code=0.
5. btn_raw[2] held past REPEAT_DELAY with ack never given -> first event code 3 stays valid; the first repeat merges into pending; the next repeat sets event_dropped=1.
6. reset asserted mid-hold with event_valid=1 -> all outputs 0 immediately; after release with the button still held, a fresh event appears 6 cycles later.
